// File: rtl/ex_mem_register.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_register
// Description : EX->MEM pipeline stage register. Latches the ALU result,
//               store data, destination register and memory/write-back
//               control. Produces lane-replicated store data, byte-lane
//               enables and a misaligned-access flag for word/half/byte
//               accesses. Resolves the branch decision for fetch.
//               Supports stall (hold) and flush (bubble insertion).
// Ports       :
//   Clk, Reset                 clock, async active-high reset
//   Stall, Flush               hold stage / insert bubble (Flush wins)
//   InValid                    EX stage holds a real instruction
//   ALUResult, Zero            ALU outputs (address / branch condition)
//   WriteData, DestReg         store data, write-back register index
//   RegWrite, MemRead, MemWrite, MemToReg, MemSize, Branch, BranchTarget
//                              control and branch inputs
//   OutValid .. MisalignErr    registered MEM-stage entry
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_register #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  InValid,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic                  Zero,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] DestReg,
  input  logic                  RegWrite,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemToReg,
  input  logic [1:0]            MemSize,
  input  logic                  Branch,
  input  logic [DATA_W-1:0]     BranchTarget,
  output logic                  OutValid,
  output logic [DATA_W-1:0]     MemAddr,
  output logic [DATA_W-1:0]     MemWData,
  output logic [3:0]            ByteEn,
  output logic                  MemRd_o,
  output logic                  MemWr_o,
  output logic                  RegWrite_o,
  output logic                  MemToReg_o,
  output logic [1:0]            MemSize_o,
  output logic [REG_ADDR_W-1:0] DestReg_o,
  output logic                  BranchTaken,
  output logic [DATA_W-1:0]     BranchPC,
  output logic                  MisalignErr
);

  localparam logic [1:0] c_SIZE_WORD = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_BYTE = 2'b10;
  // 2'b11 is reserved and handled exactly like a word access.

  localparam logic c_CHECK = (CHECK_ALIGN != 0);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [3:0]            be;
    logic                  rd;
    logic                  wr;
    logic                  regwr;
    logic                  memtoreg;
    logic [1:0]            size;
    logic [REG_ADDR_W-1:0] dest;
    logic                  bt;
    logic [DATA_W-1:0]     bpc;
    logic                  mis;
  } stage_t;

  stage_t stage_d;
  stage_t stage_q;

  logic [1:0]        w_a;
  logic              w_is_mem;
  logic              w_misaligned;
  logic              w_suppress;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;

  // Lane steering and alignment check, computed from the incoming values.
  always_comb begin
    w_a          = ALUResult[1:0];
    w_is_mem     = MemRead | MemWrite;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = WriteData;
    case (MemSize)
      c_SIZE_HALF: begin
        w_misaligned = w_a[0];
        w_be         = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {(DATA_W/16){WriteData[15:0]}};
      end
      c_SIZE_BYTE: begin
        w_misaligned = 1'b0;
        w_be         = 4'b0001 << w_a;
        w_wdata      = {(DATA_W/8){WriteData[7:0]}};
      end
      default: begin
        w_misaligned = (w_a != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = WriteData;
      end
    endcase
    // Only a load or store can be misaligned; ALU-only ops pass through
    // whatever low address bits they produce.
    w_suppress = c_CHECK && w_misaligned && w_is_mem;
  end

  // Next entry. Strobes are qualified by InValid so a non-instruction can
  // never touch memory, the register file or the PC.
  always_comb begin
    stage_d          = '0;
    stage_d.valid    = InValid;
    stage_d.addr     = ALUResult;
    stage_d.wdata    = w_wdata;
    stage_d.be       = (InValid && w_is_mem && !w_suppress) ? w_be : 4'b0000;
    stage_d.rd       = MemRead  & InValid & ~w_suppress;
    stage_d.wr       = MemWrite & InValid & ~w_suppress;
    stage_d.regwr    = RegWrite & InValid & ~w_suppress;
    stage_d.memtoreg = MemToReg & InValid;
    stage_d.size     = MemSize;
    stage_d.dest     = DestReg;
    stage_d.bt       = Branch & Zero & InValid;
    stage_d.bpc      = BranchTarget;
    stage_d.mis      = w_suppress & InValid;
  end

  // Flush outranks Stall, so a simultaneous request inserts a bubble.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stage_q <= '0;
    end else if (Flush) begin
      stage_q <= '0;
    end else if (!Stall) begin
      stage_q <= stage_d;
    end
  end

  assign OutValid    = stage_q.valid;
  assign MemAddr     = stage_q.addr;
  assign MemWData    = stage_q.wdata;
  assign ByteEn      = stage_q.be;
  assign MemRd_o     = stage_q.rd;
  assign MemWr_o     = stage_q.wr;
  assign RegWrite_o  = stage_q.regwr;
  assign MemToReg_o  = stage_q.memtoreg;
  assign MemSize_o   = stage_q.size;
  assign DestReg_o   = stage_q.dest;
  assign BranchTaken = stage_q.bt;
  assign BranchPC    = stage_q.bpc;
  assign MisalignErr = stage_q.mis;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_register
// Description : Table-driven bench for ex_mem_register with hand-written
//               sequences for reset, mid-stall reset and CHECK_ALIGN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_register;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        inv;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic [1:0]  size;
    logic        br;
    logic [31:0] tgt;
  } in_t;

  typedef struct packed {
    logic        ov;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        mtr;
    logic [1:0]  size;
    logic [4:0]  dest;
    logic        bt;
    logic [31:0] bpc;
    logic        mis;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0, Flush = 1'b0, InValid = 1'b0, Zero = 1'b0;
  logic [31:0] ALUResult = '0, WriteData = '0, BranchTarget = '0;
  logic [4:0]  DestReg = '0;
  logic        RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, MemToReg = 1'b0, Branch = 1'b0;
  logic [1:0]  MemSize = '0;

  logic        OutValid, MemRd_o, MemWr_o, RegWrite_o, MemToReg_o, BranchTaken, MisalignErr;
  logic [31:0] MemAddr, MemWData, BranchPC;
  logic [3:0]  ByteEn;
  logic [1:0]  MemSize_o;
  logic [4:0]  DestReg_o;

  logic        n_OutValid, n_MemRd_o, n_MemWr_o, n_RegWrite_o, n_MemToReg_o, n_BranchTaken, n_MisalignErr;
  logic [31:0] n_MemAddr, n_MemWData, n_BranchPC;
  logic [3:0]  n_ByteEn;
  logic [1:0]  n_MemSize_o;
  logic [4:0]  n_DestReg_o;

  int n_vec = 0;
  int n_mis = 0;

  always #5 Clk = ~Clk;

  ex_mem_register #(.DATA_W(32), .REG_ADDR_W(5), .CHECK_ALIGN(1)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .ALUResult(ALUResult), .Zero(Zero), .WriteData(WriteData), .DestReg(DestReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .MemSize(MemSize), .Branch(Branch), .BranchTarget(BranchTarget),
    .OutValid(OutValid), .MemAddr(MemAddr), .MemWData(MemWData), .ByteEn(ByteEn),
    .MemRd_o(MemRd_o), .MemWr_o(MemWr_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .MemSize_o(MemSize_o), .DestReg_o(DestReg_o), .BranchTaken(BranchTaken),
    .BranchPC(BranchPC), .MisalignErr(MisalignErr)
  );

  ex_mem_register #(.DATA_W(32), .REG_ADDR_W(5), .CHECK_ALIGN(0)) dut_na (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .ALUResult(ALUResult), .Zero(Zero), .WriteData(WriteData), .DestReg(DestReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .MemSize(MemSize), .Branch(Branch), .BranchTarget(BranchTarget),
    .OutValid(n_OutValid), .MemAddr(n_MemAddr), .MemWData(n_MemWData), .ByteEn(n_ByteEn),
    .MemRd_o(n_MemRd_o), .MemWr_o(n_MemWr_o), .RegWrite_o(n_RegWrite_o), .MemToReg_o(n_MemToReg_o),
    .MemSize_o(n_MemSize_o), .DestReg_o(n_DestReg_o), .BranchTaken(n_BranchTaken),
    .BranchPC(n_BranchPC), .MisalignErr(n_MisalignErr)
  );

  function automatic out_t act();
    return '{OutValid, MemAddr, MemWData, ByteEn, MemRd_o, MemWr_o, RegWrite_o,
             MemToReg_o, MemSize_o, DestReg_o, BranchTaken, BranchPC, MisalignErr};
  endfunction

  function automatic out_t act_na();
    return '{n_OutValid, n_MemAddr, n_MemWData, n_ByteEn, n_MemRd_o, n_MemWr_o, n_RegWrite_o,
             n_MemToReg_o, n_MemSize_o, n_DestReg_o, n_BranchTaken, n_BranchPC, n_MisalignErr};
  endfunction

  task automatic check(input string name, input out_t a, input out_t e);
    n_vec++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL %s: got ov=%b addr=%h wd=%h be=%b rd=%b wr=%b rw=%b mtr=%b sz=%b dst=%0d bt=%b bpc=%h mis=%b | expected ov=%b addr=%h wd=%h be=%b rd=%b wr=%b rw=%b mtr=%b sz=%b dst=%0d bt=%b bpc=%h mis=%b",
               name, a.ov, a.addr, a.wd, a.be, a.rd, a.wr, a.rw, a.mtr, a.size, a.dest, a.bt, a.bpc, a.mis,
               e.ov, e.addr, e.wd, e.be, e.rd, e.wr, e.rw, e.mtr, e.size, e.dest, e.bt, e.bpc, e.mis);
    end
  endtask

  task automatic drive(input in_t v);
    Stall = v.stall; Flush = v.flush; InValid = v.inv; ALUResult = v.alu; Zero = v.zero;
    WriteData = v.wd; DestReg = v.dest; RegWrite = v.rw; MemRead = v.mr; MemWrite = v.mw;
    MemToReg = v.mtr; MemSize = v.size; Branch = v.br; BranchTarget = v.tgt;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  vec_t vecs[24];
  out_t zero_o;
  in_t  zero_i;

  initial begin
    zero_o = '0;
    zero_i = '0;
    // name, {stall,flush,inv,alu,zero,wd,dest,rw,mr,mw,mtr,size,br,tgt},
    //       {ov,addr,wd,be,rd,wr,rw,mtr,size,dest,bt,bpc,mis}
    vecs[0]  = '{"sw_1000",
      '{1'b0,1'b0,1'b1,32'h1000,1'b0,32'hDEADBEEF,5'd0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h1000,32'hDEADBEEF,4'b1111,1'b0,1'b1,1'b0,1'b0,2'b00,5'd0,1'b0,32'h0,1'b0}};
    vecs[1]  = '{"sb_1003",
      '{1'b0,1'b0,1'b1,32'h1003,1'b0,32'h000000A5,5'd0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,32'h0},
      '{1'b1,32'h1003,32'hA5A5A5A5,4'b1000,1'b0,1'b1,1'b0,1'b0,2'b10,5'd0,1'b0,32'h0,1'b0}};
    vecs[2]  = '{"sh_1002",
      '{1'b0,1'b0,1'b1,32'h1002,1'b0,32'h00001234,5'd0,1'b0,1'b0,1'b1,1'b0,2'b01,1'b0,32'h0},
      '{1'b1,32'h1002,32'h12341234,4'b1100,1'b0,1'b1,1'b0,1'b0,2'b01,5'd0,1'b0,32'h0,1'b0}};
    vecs[3]  = '{"sh_1000",
      '{1'b0,1'b0,1'b1,32'h1000,1'b0,32'hFFFFBEEF,5'd0,1'b0,1'b0,1'b1,1'b0,2'b01,1'b0,32'h0},
      '{1'b1,32'h1000,32'hBEEFBEEF,4'b0011,1'b0,1'b1,1'b0,1'b0,2'b01,5'd0,1'b0,32'h0,1'b0}};
    vecs[4]  = '{"lw_misaligned_1002",
      '{1'b0,1'b0,1'b1,32'h1002,1'b0,32'h0,5'd7,1'b1,1'b1,1'b0,1'b1,2'b00,1'b0,32'h0},
      '{1'b1,32'h1002,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b1,2'b00,5'd7,1'b0,32'h0,1'b1}};
    vecs[5]  = '{"lb_1001",
      '{1'b0,1'b0,1'b1,32'h1001,1'b0,32'h0,5'd3,1'b1,1'b1,1'b0,1'b1,2'b10,1'b0,32'h0},
      '{1'b1,32'h1001,32'h0,4'b0010,1'b1,1'b0,1'b1,1'b1,2'b10,5'd3,1'b0,32'h0,1'b0}};
    vecs[6]  = '{"lh_misaligned_1001",
      '{1'b0,1'b0,1'b1,32'h1001,1'b0,32'h0,5'd3,1'b1,1'b1,1'b0,1'b1,2'b01,1'b0,32'h0},
      '{1'b1,32'h1001,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b1,2'b01,5'd3,1'b0,32'h0,1'b1}};
    vecs[7]  = '{"sw_not_valid",
      '{1'b0,1'b0,1'b0,32'h1000,1'b0,32'h11111111,5'd0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,32'h0},
      '{1'b0,32'h1000,32'h11111111,4'b0000,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0,1'b0,32'h0,1'b0}};
    vecs[8]  = '{"add_odd_result",
      '{1'b0,1'b0,1'b1,32'h6,1'b0,32'h0,5'd9,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h6,32'h0,4'b0000,1'b0,1'b0,1'b1,1'b0,2'b00,5'd9,1'b0,32'h0,1'b0}};
    vecs[9]  = '{"sw_reserved_size",
      '{1'b0,1'b0,1'b1,32'h1004,1'b0,32'hCAFEF00D,5'd0,1'b0,1'b0,1'b1,1'b0,2'b11,1'b0,32'h0},
      '{1'b1,32'h1004,32'hCAFEF00D,4'b1111,1'b0,1'b1,1'b0,1'b0,2'b11,5'd0,1'b0,32'h0,1'b0}};
    vecs[10] = '{"beq_taken",
      '{1'b0,1'b0,1'b1,32'h0,1'b1,32'h0,5'd0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,32'h40},
      '{1'b1,32'h0,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0,1'b1,32'h40,1'b0}};
    vecs[11] = '{"beq_stall_1",
      '{1'b1,1'b0,1'b1,32'h2000,1'b0,32'h0,5'd2,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h0,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0,1'b1,32'h40,1'b0}};
    vecs[12] = '{"beq_stall_2",
      '{1'b1,1'b0,1'b1,32'h2000,1'b0,32'h0,5'd2,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h0,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0,1'b1,32'h40,1'b0}};
    vecs[13] = '{"after_branch_stall",
      '{1'b0,1'b0,1'b1,32'h20,1'b0,32'h0,5'd1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h20,32'h0,4'b0000,1'b0,1'b0,1'b1,1'b0,2'b00,5'd1,1'b0,32'h0,1'b0}};
    vecs[14] = '{"beq_not_taken",
      '{1'b0,1'b0,1'b1,32'h4,1'b0,32'h0,5'd0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,32'h80},
      '{1'b1,32'h4,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0,1'b0,32'h80,1'b0}};
    vecs[15] = '{"add_valid",
      '{1'b0,1'b0,1'b1,32'h55,1'b0,32'h0,5'd4,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h55,32'h0,4'b0000,1'b0,1'b0,1'b1,1'b0,2'b00,5'd4,1'b0,32'h0,1'b0}};
    vecs[16] = '{"stall_and_flush",
      '{1'b1,1'b1,1'b1,32'h66,1'b0,32'h0,5'd5,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      zero_o};
    vecs[17] = '{"add_after_bubble",
      '{1'b0,1'b0,1'b1,32'h77,1'b0,32'h0,5'd6,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h77,32'h0,4'b0000,1'b0,1'b0,1'b1,1'b0,2'b00,5'd6,1'b0,32'h0,1'b0}};
    vecs[18] = '{"sw_2000",
      '{1'b0,1'b0,1'b1,32'h2000,1'b0,32'h12345678,5'd0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h2000,32'h12345678,4'b1111,1'b0,1'b1,1'b0,1'b0,2'b00,5'd0,1'b0,32'h0,1'b0}};
    vecs[19] = '{"sw_held_by_stall",
      '{1'b1,1'b0,1'b1,32'h3000,1'b0,32'h0,5'd8,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      '{1'b1,32'h2000,32'h12345678,4'b1111,1'b0,1'b1,1'b0,1'b0,2'b00,5'd0,1'b0,32'h0,1'b0}};
    vecs[20] = '{"flush_store",
      '{1'b0,1'b1,1'b1,32'h3000,1'b0,32'h9,5'd0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,32'h0},
      zero_o};
    vecs[21] = '{"sb_2000",
      '{1'b0,1'b0,1'b1,32'h2000,1'b0,32'h0000003C,5'd0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,32'h0},
      '{1'b1,32'h2000,32'h3C3C3C3C,4'b0001,1'b0,1'b1,1'b0,1'b0,2'b10,5'd0,1'b0,32'h0,1'b0}};
    vecs[22] = '{"beq_taken_100",
      '{1'b0,1'b0,1'b1,32'h8,1'b1,32'h0,5'd0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,32'h100},
      '{1'b1,32'h8,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0,1'b1,32'h100,1'b0}};
    vecs[23] = '{"flush_clears_branch",
      '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,5'd0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0},
      zero_o};

    // Asynchronous reset with arbitrary inputs, observed before any edge.
    #1;
    Reset = 1'b1;
    InValid = 1'b1; ALUResult = $urandom; WriteData = $urandom; BranchTarget = $urandom;
    Zero = 1'b1; Branch = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
    MemToReg = 1'b1; DestReg = 5'd17; MemSize = 2'b10;
    #2;
    check("reset_async", act(), zero_o);
    check("reset_async_na", act_na(), zero_o);
    repeat (2) tick();
    check("reset_held", act(), zero_o);
    drive(zero_i);
    Reset = 1'b0;
    tick();
    check("after_release", act(), zero_o);

    // Directed vector table.
    for (int k = 0; k < 24; k++) begin
      drive(vecs[k].i);
      tick();
      check(vecs[k].name, act(), vecs[k].o);
    end

    // Alignment checking off: misaligned accesses go through unflagged.
    drive('{1'b0,1'b0,1'b1,32'h1002,1'b0,32'h0,5'd7,1'b1,1'b1,1'b0,1'b1,2'b00,1'b0,32'h0});
    tick();
    check("na_lw_1002", act_na(),
      '{1'b1,32'h1002,32'h0,4'b1111,1'b1,1'b0,1'b1,1'b1,2'b00,5'd7,1'b0,32'h0,1'b0});
    check("chk_lw_1002", act(),
      '{1'b1,32'h1002,32'h0,4'b0000,1'b0,1'b0,1'b0,1'b1,2'b00,5'd7,1'b0,32'h0,1'b1});
    drive('{1'b0,1'b0,1'b1,32'h1001,1'b0,32'h0000ABCD,5'd0,1'b0,1'b0,1'b1,1'b0,2'b01,1'b0,32'h0});
    tick();
    check("na_sh_1001", act_na(),
      '{1'b1,32'h1001,32'hABCDABCD,4'b0011,1'b0,1'b1,1'b0,1'b0,2'b01,5'd0,1'b0,32'h0,1'b0});
    check("chk_sh_1001", act(),
      '{1'b1,32'h1001,32'hABCDABCD,4'b0000,1'b0,1'b0,1'b0,1'b0,2'b01,5'd0,1'b0,32'h0,1'b1});

    // Reset in the middle of a stall empties the stage.
    drive('{1'b0,1'b0,1'b1,32'h4000,1'b0,32'h0BADF00D,5'd0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,32'h0});
    tick();
    check("sw_4000", act(),
      '{1'b1,32'h4000,32'h0BADF00D,4'b1111,1'b0,1'b1,1'b0,1'b0,2'b00,5'd0,1'b0,32'h0,1'b0});
    Stall = 1'b1;
    tick();
    #2;
    Reset = 1'b1;
    #1;
    check("reset_mid_stall", act(), zero_o);
    #1;
    Reset = 1'b0;
    tick();
    check("stall_after_reset", act(), zero_o);
    drive('{1'b0,1'b0,1'b1,32'h88,1'b0,32'h0,5'd10,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,32'h0});
    tick();
    check("capture_after_reset", act(),
      '{1'b1,32'h88,32'h0,4'b0000,1'b0,1'b0,1'b1,1'b0,2'b00,5'd10,1'b0,32'h0,1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
